// File: rtl/uart_tx_serializer_if.sv
// TX FIFO read-side bundle shared by the FIFO and the UART transmit serializer.
// Latency: n/a (wires only); data is the FIFO's registered read output.
// Backpressure: none; the reader pops with a one-cycle strobe only when not empty.
//
// Signals:
//   i_fifo_data_w  - FIFO registered read data (valid the cycle after the strobe)
//   i_fifo_empty_w - FIFO empty flag
//   o_fifo_read_w  - one-cycle read strobe from the serializer
// Modports:
//   master - serializer side (drives the read strobe, consumes data/empty)
//   slave  - FIFO side (drives data/empty, consumes the read strobe)
interface uart_tx_serializer_if #(
    parameter int DATA_BITS = 8
);
    logic [DATA_BITS-1:0] i_fifo_data_w;
    logic                 i_fifo_empty_w;
    logic                 o_fifo_read_w;

    modport master (
        input  i_fifo_data_w,
        input  i_fifo_empty_w,
        output o_fifo_read_w
    );

    modport slave (
        output i_fifo_data_w,
        output i_fifo_empty_w,
        input  o_fifo_read_w
    );
endinterface

// File: rtl/uart_tx_serializer.sv
// UART transmit engine: pops bytes from the TX FIFO and sends them 8N1 (8E1 with parity), LSB first.
// Latency: first start-bit low on o_tx_w appears 3 edges after the edge that sees enable & !empty.
// Backpressure: fetches only while enabled and the FIFO is non-empty; a started frame always completes.
//
// Ports:
//   i_clk        - system clock
//   i_reset_n_w  - asynchronous active-low reset (line goes high immediately, popped byte dropped)
//   i_enable_w   - permits fetching new bytes (checked in IDLE and at the end of STOP)
//   fifo_if      - FIFO read side: data, empty flag, one-cycle read strobe (master modport)
//   o_tx_w       - serial line, idle high
//   o_busy_w     - high in every state except IDLE
//
// Build option: define UART_TX_PARITY_EN to insert an even-parity bit between the data bits and
// the stop bit (11 bit periods per frame). Left undefined, no parity state or logic exists.
module uart_tx_serializer #(
    parameter int DATA_BITS      = 8,
    parameter int CLKS_PER_BAUD  = 868,
    parameter int BAUD_CNT_WIDTH = 16
) (
    input  logic                 i_clk,
    input  logic                 i_reset_n_w,
    input  logic                 i_enable_w,
    uart_tx_serializer_if.master fifo_if,
    output logic                 o_tx_w,
    output logic                 o_busy_w
);

    localparam int IDX_W = (DATA_BITS > 1) ? $clog2(DATA_BITS) : 1;

    localparam logic [BAUD_CNT_WIDTH-1:0] BAUD_LAST = BAUD_CNT_WIDTH'(CLKS_PER_BAUD - 1);
    localparam logic [IDX_W-1:0]          IDX_LAST  = IDX_W'(DATA_BITS - 1);

`ifdef UART_TX_PARITY_EN
    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        FETCH  = 3'd1,
        LOAD   = 3'd2,
        START  = 3'd3,
        DATA   = 3'd4,
        PARITY = 3'd5,
        STOP   = 3'd6
    } state_t;
`else
    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        FETCH  = 3'd1,
        LOAD   = 3'd2,
        START  = 3'd3,
        DATA   = 3'd4,
        STOP   = 3'd6
    } state_t;
`endif

    state_t                    state_q;
    logic [BAUD_CNT_WIDTH-1:0] baud_q;
    logic [IDX_W-1:0]          bit_idx_q;
    logic [DATA_BITS-1:0]      shift_q;
    logic                      tx_q;
    logic                      rd_q;
    logic                      busy_q;
`ifdef UART_TX_PARITY_EN
    logic                      parity_q;
`endif

    // Launch a new byte: enabled and something is waiting in the FIFO.
    logic launch;
    // Last clock of the current bit period.
    logic baud_last;

    assign launch    = i_enable_w & ~fifo_if.i_fifo_empty_w;
    assign baud_last = (baud_q == BAUD_LAST);

    always_ff @(posedge i_clk or negedge i_reset_n_w) begin
        if (!i_reset_n_w) begin
            state_q   <= IDLE;
            baud_q    <= '0;
            bit_idx_q <= '0;
            shift_q   <= '0;
            tx_q      <= 1'b1;
            rd_q      <= 1'b0;
            busy_q    <= 1'b0;
`ifdef UART_TX_PARITY_EN
            parity_q  <= 1'b0;
`endif
        end else begin
            // The read strobe is a single-cycle pulse; only the FETCH entry sets it.
            rd_q <= 1'b0;

            case (state_q)
                IDLE: begin
                    if (launch) begin
                        state_q <= FETCH;
                        rd_q    <= 1'b1;
                        busy_q  <= 1'b1;
                    end
                end

                // The FIFO updates its read register on the edge that ends FETCH.
                FETCH: begin
                    state_q <= LOAD;
                end

                LOAD: begin
                    shift_q   <= fifo_if.i_fifo_data_w;
`ifdef UART_TX_PARITY_EN
                    parity_q  <= ^fifo_if.i_fifo_data_w;
`endif
                    baud_q    <= '0;
                    bit_idx_q <= '0;
                    state_q   <= START;
                end

                START: begin
                    if (baud_last) begin
                        baud_q  <= '0;
                        state_q <= DATA;
                    end else begin
                        baud_q  <= baud_q + 1'b1;
                    end
                end

                DATA: begin
                    if (baud_last) begin
                        baud_q  <= '0;
                        shift_q <= shift_q >> 1;
                        if (bit_idx_q == IDX_LAST) begin
                            bit_idx_q <= '0;
`ifdef UART_TX_PARITY_EN
                            state_q   <= PARITY;
`else
                            state_q   <= STOP;
`endif
                        end else begin
                            bit_idx_q <= bit_idx_q + 1'b1;
                        end
                    end else begin
                        baud_q <= baud_q + 1'b1;
                    end
                end

`ifdef UART_TX_PARITY_EN
                PARITY: begin
                    if (baud_last) begin
                        baud_q  <= '0;
                        state_q <= STOP;
                    end else begin
                        baud_q  <= baud_q + 1'b1;
                    end
                end
`endif

                STOP: begin
                    if (baud_last) begin
                        baud_q <= '0;
                        // Chaining straight into FETCH skips IDLE, so back-to-back
                        // stop bits stretch by the FETCH and LOAD cycles.
                        if (launch) begin
                            state_q <= FETCH;
                            rd_q    <= 1'b1;
                        end else begin
                            state_q <= IDLE;
                            busy_q  <= 1'b0;
                        end
                    end else begin
                        baud_q <= baud_q + 1'b1;
                    end
                end

                default: begin
                    state_q <= IDLE;
                    busy_q  <= 1'b0;
                end
            endcase

            // The line register follows the state one cycle behind; every bit
            // is delayed by the same amount, so bit widths are unaffected.
            case (state_q)
                START:   tx_q <= 1'b0;
                DATA:    tx_q <= shift_q[0];
`ifdef UART_TX_PARITY_EN
                PARITY:  tx_q <= parity_q;
`endif
                default: tx_q <= 1'b1;
            endcase
        end
    end

    assign o_tx_w                = tx_q;
    assign o_busy_w              = busy_q;
    assign fifo_if.o_fifo_read_w = rd_q;

endmodule

// File: tb/tb_uart_tx_serializer.sv
// Scoreboard bench for uart_tx_serializer: bytes pushed into a FIFO model are queued as
// expected frames; a line monitor rebuilds each frame from o_tx_w and compares it.
module tb_uart_tx_serializer;

    localparam int CLKS = 4;
`ifdef UART_TX_PARITY_EN
    localparam int NB = 11;
`else
    localparam int NB = 10;
`endif
    localparam int FRAME = NB * CLKS;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic enable = 1'b0;
    logic tx;
    logic busy;

    uart_tx_serializer_if #(.DATA_BITS(8)) fifo_if ();

    uart_tx_serializer #(
        .DATA_BITS     (8),
        .CLKS_PER_BAUD (CLKS),
        .BAUD_CNT_WIDTH(16)
    ) dut (
        .i_clk      (clk),
        .i_reset_n_w(rst_n),
        .i_enable_w (enable),
        .fifo_if    (fifo_if),
        .o_tx_w     (tx),
        .o_busy_w   (busy)
    );

    always #5 clk = ~clk;

    // ---------------- bookkeeping ----------------
    int n_checks = 0;
    int n_fail   = 0;

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, got, exp, $time);
        end
    endtask

    // ---------------- FIFO model ----------------
    logic [7:0] mem [0:255];
    logic [7:0] exp_q [$];
    int n_push = 0;
    int n_pop  = 0;

    assign fifo_if.i_fifo_empty_w = (n_push == n_pop);

    initial begin
        fifo_if.i_fifo_data_w = 8'h00;
        forever begin
            @(posedge clk);
            if (fifo_if.o_fifo_read_w === 1'b1 && n_pop != n_push) begin
                fifo_if.i_fifo_data_w <= mem[n_pop[7:0]];
                n_pop <= n_pop + 1;
            end
        end
    end

    task automatic push(input logic [7:0] b);
        mem[n_push[7:0]] = b;
        n_push++;
        exp_q.push_back(b);
    endtask

    // Reference frame: start 0, data LSB first, optional even parity, stop 1.
    function automatic logic exp_bit(input logic [7:0] b, input int k);
        if (k == 0) return 1'b0;
        if (k <= 8) return b[k-1];
        if (NB == 11 && k == 9) return ^b;
        return 1'b1;
    endfunction

    // ---------------- monitor ----------------
    int   cyc = 0;
    int   start_cyc = 0;
    int   last_read_cyc = -100;
    int   gap = 0;
    int   last_gap = 0;
    int   rd_seen = 0;
    int   idx = 0;
    bit   in_frame = 1'b0;
    logic prev_read = 1'b0;
    logic prev_busy = 1'b0;
    logic samp [0:63];

    initial begin
        logic [7:0]  b;
        logic [15:0] got_bits;
        logic [15:0] exp_bits;
        logic        hold_ok;
        forever begin
            @(negedge clk);
            cyc++;
            if (!rst_n) begin
                in_frame  = 1'b0;
                gap       = 0;
                prev_read = 1'b0;
                prev_busy = 1'b0;
            end else begin
                if (fifo_if.o_fifo_read_w === 1'b1) begin
                    check("rd_while_empty", fifo_if.i_fifo_empty_w, 1'b0);
                    check("rd_pulse_single", prev_read, 1'b0);
                    last_read_cyc = cyc;
                    rd_seen++;
                end
                prev_read = fifo_if.o_fifo_read_w;

                if (!in_frame) begin
                    if (tx === 1'b0) begin
                        in_frame  = 1'b1;
                        idx       = 0;
                        start_cyc = cyc;
                        last_gap  = gap;
                        check("start_latency", cyc - last_read_cyc, 3);
                    end else begin
                        gap++;
                    end
                end

                if (in_frame) begin
                    samp[idx] = tx;
                    idx++;
                    if (idx == FRAME) begin
                        in_frame = 1'b0;
                        gap      = 0;
                        if (exp_q.size() == 0) begin
                            check("frame_unexpected", 32'd1, 32'd0);
                        end else begin
                            b        = exp_q.pop_front();
                            got_bits = '0;
                            exp_bits = '0;
                            hold_ok  = 1'b1;
                            for (int k = 0; k < NB; k++) begin
                                exp_bits[k] = exp_bit(b, k);
                                got_bits[k] = samp[k*CLKS + CLKS/2];
                                for (int c = 0; c < CLKS; c++)
                                    if (samp[k*CLKS + c] !== exp_bit(b, k)) hold_ok = 1'b0;
                            end
                            check("frame_bits", got_bits, exp_bits);
                            check("frame_bit_timing", hold_ok, 1'b1);
                        end
                    end
                end

                if (prev_busy && !busy)
                    check("busy_fall_time", cyc - start_cyc, FRAME - 1);
                prev_busy = busy;
            end
        end
    end

    // ---------------- bounded waits ----------------
    task automatic wait_busy(input logic level, input int maxc, input string name);
        int n = 0;
        while (busy !== level && n < maxc) begin
            @(negedge clk);
            n++;
        end
        check(name, busy, level);
    endtask

    task automatic wait_start(input int maxc);
        int n = 0;
        while (!in_frame && n < maxc) begin
            @(negedge clk);
            n++;
        end
        check("saw_start_bit", in_frame, 1'b1);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not complete in time");
        $fatal(1);
    end

    // ---------------- stimulus ----------------
    initial begin
        int rd0;
        logic [7:0] b;

        // Reset held with enable=1 and a byte waiting: outputs must stay idle.
        enable = 1'b1;
        @(negedge clk);
        push(8'hA5);
        repeat (4) begin
            @(negedge clk);
            check("rst_tx", tx, 1'b1);
            check("rst_rd", fifo_if.o_fifo_read_w, 1'b0);
            check("rst_busy", busy, 1'b0);
        end
        rst_n = 1'b1;
        @(negedge clk);
        check("rel_fetch_rd", fifo_if.o_fifo_read_w, 1'b1);
        check("rel_fetch_busy", busy, 1'b1);
        wait_busy(1'b0, FRAME + 10, "a5_done");
        check("a5_reads", rd_seen, 1);

        // Single frames: parity corner bytes then random ones, random idle gaps.
        for (int i = 0; i < 8; i++) begin
            if (i == 0)      b = 8'h07;
            else if (i == 1) b = 8'h03;
            else             b = 8'($urandom);
            push(b);
            wait_busy(1'b1, 10, "single_go");
            wait_busy(1'b0, FRAME + 10, "single_done");
            repeat ($urandom_range(0, 5)) @(negedge clk);
        end

        // Back-to-back: stop bit stretches by the two fetch cycles.
        rd0 = rd_seen;
        push(8'h00);
        push(8'hFF);
        wait_busy(1'b1, 10, "b2b_go");
        wait_busy(1'b0, 2*FRAME + 20, "b2b_done");
        check("b2b_reads", rd_seen - rd0, 2);
        check("b2b_stop_extra", last_gap, 2);

        // Random burst.
        for (int i = 0; i < 4; i++) push(8'($urandom));
        wait_busy(1'b1, 10, "burst_go");
        wait_busy(1'b0, 4*FRAME + 40, "burst_done");

        // Enable dropped during data bit 3: frame completes, no further fetch.
        rd0 = rd_seen;
        push(8'h3C);
        push(8'h81);
        wait_busy(1'b1, 10, "en_go");
        wait_start(10);
        repeat ((1 + 3) * CLKS + 1) @(negedge clk);
        enable = 1'b0;
        wait_busy(1'b0, FRAME + 10, "en_first_done");
        check("en_reads_one", rd_seen - rd0, 1);
        repeat (20) @(negedge clk);
        check("en_still_idle", busy, 1'b0);
        check("en_no_read", rd_seen - rd0, 1);
        enable = 1'b1;
        wait_busy(1'b1, 10, "en_resume_go");
        wait_busy(1'b0, FRAME + 10, "en_resume_done");
        check("en_reads_two", rd_seen - rd0, 2);

        // Asynchronous reset during data bit 5, between clock edges.
        push(8'h96);
        push(8'h4B);
        wait_busy(1'b1, 10, "ar_go");
        wait_start(10);
        repeat ((1 + 5) * CLKS + 1) @(negedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        check("ar_tx_high", tx, 1'b1);
        check("ar_busy_low", busy, 1'b0);
        check("ar_rd_low", fifo_if.o_fifo_read_w, 1'b0);
        void'(exp_q.pop_front()); // the aborted byte is never sent
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        wait_busy(1'b1, 10, "ar_resume_go");
        wait_busy(1'b0, FRAME + 10, "ar_resume_done");

        repeat (5) @(negedge clk);
        check("all_frames_seen", exp_q.size(), 0);
        check("fifo_drained", n_push - n_pop, 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
